// File: rtl/mod4_seq_ctrl_pkg.sv
// Shared definitions for the mod4 sequencer: FSM state encoding, default
// parameter values and the width of the WAIT down-counter.
package mod4_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LAT_DEF = 1;  // datapath latency, legal 1..15
  localparam int CW_DEF  = 8;  // completed-transaction counter width
  localparam int TW      = 4;  // wait-counter width, holds LAT-1 up to 14

endpackage

// File: rtl/mod4_seq_ctrl_if.sv
// Request/response handshake bundle between a stimulus source and the
// sequencer. The master drives requests and consumes responses; the slave
// (the sequencer) does the opposite.
interface mod4_seq_ctrl_if;

  logic       req_valid;
  logic [1:0] req_sym;
  logic       req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_fg;
  logic       rsp_ready;

  modport master (
    output req_valid, req_sym, rsp_ready,
    input  req_ready, rsp_valid, rsp_fg
  );

  modport slave (
    input  req_valid, req_sym, rsp_ready,
    output req_ready, rsp_valid, rsp_fg
  );

endinterface

// File: rtl/mod4_seq_timer.sv
// Loadable down-counter with a zero flag; paces the WAIT state so the
// datapath output is sampled exactly LAT edges after the symbol is applied.
module mod4_seq_timer
  import mod4_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] cnt;

  // Counter register: load wins over decrement, never underflows below zero.
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mod4_seq_ctrl.sv
// Transaction sequencer for the modulo4 datapath: accepts a 2-bit symbol,
// applies it on D1/D2, waits LAT cycles, captures {f,g} and hands it back
// over the response port. Counts completed responses modulo 2^CW.
module mod4_seq_ctrl
  import mod4_seq_ctrl_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic          CLK1,
  input  logic          RST,
  mod4_seq_ctrl_if.slave bus,
  output logic          D1,
  output logic          D2,
  input  logic          f,
  input  logic          g,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam logic [TW-1:0] WAIT_INIT = TW'(LAT - 1);

  state_t state;
  state_t state_nxt;
  logic   timer_load;
  logic   timer_dec;
  logic   timer_zero;
  logic   capture;
  logic   done;

  mod4_seq_timer u_timer (
    .clk      (CLK1),
    .rst      (RST),
    .load     (timer_load),
    .load_val (WAIT_INIT),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // State register; reset dominates any handshake in progress.
  always_ff @(posedge CLK1) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A simultaneous rsp_ready is irrelevant here: only the request counts.
        if (bus.req_valid) begin
          timer_load = 1'b1;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: applied symbol, captured response and completion count.
  // D1/D2 keep the last symbol after the transaction; only reset clears them.
  always_ff @(posedge CLK1) begin
    if (RST) begin
      D1            <= 1'b0;
      D2            <= 1'b0;
      bus.rsp_fg    <= 2'b00;
      bus.rsp_valid <= 1'b0;
      count         <= '0;
    end else begin
      if (timer_load) begin
        {D1, D2} <= bus.req_sym;
      end
      if (capture) begin
        bus.rsp_fg    <= {f, g};
        bus.rsp_valid <= 1'b1;
      end
      if (done) begin
        bus.rsp_valid <= 1'b0;
        count         <= count + 1'b1;
      end
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);

endmodule

// File: doc/mod4_seq_ctrl.md
# mod4_seq_ctrl

Transaction sequencer that drives the `modulo4` datapath. It accepts 2-bit symbols over a valid/ready request port and applies each one to `modulo4` as `D1`/`D2`. After a fixed datapath latency it captures `f`/`g` and returns them over a valid/ready response port. It sits between the stimulus source (tester or upstream logic) and `modulo4`, and is the only driver of `D1`/`D2` in the integrated design.

## Interface
- `LAT`, default 1: cycles from `D1`/`D2` update to a valid `f`/`g`; legal range 1..15.
- `CW`, default 8: width of the completed-transaction counter.

- `CLK1`  in  1  single clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request symbol present.
- `req_sym`  in  2  symbol to apply; bit 1 goes to `D1`, bit 0 goes to `D2`.
- `req_ready`  out  1  controller accepts a request this cycle.
- `D1`  out  1  datapath input, registered.
- `D2`  out  1  datapath input, registered.
- `f`  in  1  datapath output.
- `g`  in  1  datapath output.
- `rsp_valid`  out  1  response held.
- `rsp_fg`  out  2  captured `{f,g}`.
- `rsp_ready`  in  1  consumer takes the response.
- `busy`  out  1  high whenever the state is not IDLE.
- `count`  out  CW  number of completed responses; wraps modulo 2^CW.

## Operation
- FSM states: IDLE, WAIT, RESP. Encoding lives in a shared header.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: `{D1,D2}`<=`req_sym`, wait counter <= `LAT`-1, go to WAIT.
- WAIT
  - `req_ready`=0. `D1`/`D2` held stable.
  - While counter≠0: decrement.
  - When counter==0: `rsp_fg`<=`{f,g}`, `rsp_valid`<=1, go to RESP.
- RESP
  - `rsp_valid`=1. `rsp_fg` is stable and `req_ready`=0.
  - On `rsp_ready`: `rsp_valid`<=0, `count`<=`count`+1, go to IDLE.
- `D1`/`D2` retain the last applied symbol in IDLE; they are not returned to 0.
- `count` wraps from 2^CW−1 to 0 with no flag.
- `req_sym` is ignored when `req_valid`=0.
- `rsp_ready` is ignored outside RESP.
- In IDLE, `req_valid` and `rsp_ready` asserted together: only the request handshake applies.

## Timing
- Request accepted at edge k (`req_valid`&`req_ready` sampled high):
  - `D1`/`D2` show the new symbol after edge k.
  - `f`/`g` are sampled at edge k+`LAT`.
  - `rsp_valid` is high after edge k+`LAT`.
- Earliest response handshake is at edge k+`LAT`+1. IDLE follows, so the next request is accepted no earlier than edge k+`LAT`+2.
- Peak throughput: one transaction per `LAT`+2 cycles.
- Reset (`RST` high at an edge) returns every output to its reset value, in any state:
  - state=IDLE, `req_ready`=1 (combinational from state), `busy`=0;
  - `D1`=0, `D2`=0, `rsp_valid`=0, `rsp_fg`=0, `count`=0.
- Reset mid-transaction discards the transaction: no response is produced and `count` is not incremented.
- Reset dominates any simultaneous handshake.
- Response back-pressure (`rsp_ready` low) may last indefinitely. During it, `D1`/`D2`, `rsp_fg` and `count` hold.

## Structure
- Shared header `mod4_defs.vh` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_WAIT`=2'd1, `ST_RESP`=2'd2;
  - default `LAT`/`CW` values and the 4-bit wait-counter width.
- `busy` = (state≠`ST_IDLE`); `req_ready` = (state==`ST_IDLE`).
- Optional sub-module `mod4_seq_timer`: a loadable down-counter with a zero flag, used for WAIT.
- Top-level integration instantiates `mod4_seq_ctrl` and `modulo4` side by side on a shared `CLK1`/`RST`. `D1`/`D2`/`f`/`g` are wired point-to-point.

## Test plan
- **Reset:** hold `RST` 2 cycles with `req_valid`=1 → `D1`=`D2`=0, `rsp_valid`=0, `count`=0, `req_ready`=1, `busy`=0 throughout.
- **Single transaction, `LAT`=1:** `req_sym`=2'b10 accepted at edge k → `D1`=1, `D2`=0 after k; `rsp_valid`=1 after k+1; `rsp_fg` equals `{f,g}` sampled at k+1; with `rsp_ready`=1, `count`=1 after k+2.
- **Back-pressure:** `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`, `rsp_fg` and `D1`/`D2` stable; `req_ready`=0; a new `req_valid` is not accepted until after the response handshake.
- **Back-to-back, `LAT`=3:** stream symbols 0,1,2,3 with `req_valid` and `rsp_ready` held high → accepts spaced exactly 5 cycles apart; 4 responses each matching the reference-model `{f,g}`; `count`=4.
- **Reset mid-WAIT:** assert `RST` 1 cycle after accept with `LAT`=3 → no `rsp_valid` pulse, `count` unchanged at 0, `D1`=`D2`=0, IDLE on the next cycle.
- **Counter wrap, `CW`=2:** complete 5 transactions → `count` sequence 1,2,3,0,1.
